// File: rtl/one_wire_slave_tx_if.sv
// Slave-side 1-Wire transmit bundle: bus sense/drive, byte load handshake and event pulses.
interface one_wire_slave_tx_if;
    logic       enable;
    logic       bus_in;
    logic       bus_pull_low;
    logic       load;
    logic [7:0] tx_byte;
    logic       ready;
    logic       busy;
    logic       done;
    logic       reset_seen;
    logic       presence_done;

    modport slave (
        input  enable, bus_in, load, tx_byte,
        output bus_pull_low, ready, busy, done, reset_seen, presence_done
    );

    modport master (
        output enable, bus_in, load, tx_byte,
        input  bus_pull_low, ready, busy, done, reset_seen, presence_done
    );
endinterface

// File: rtl/one_wire_slave_tx.sv
// 1-Wire slave responder: presence pulse after master reset, returns a loaded byte LSB first.
// Latency: line pulled 3 clk edges after bus falls; load accepted only when ready (no queueing).
module one_wire_slave_tx #(
    parameter int RESET_MIN_CYC = 480,
    parameter int PRES_WAIT_CYC = 30,
    parameter int PRES_LEN_CYC  = 120,
    parameter int HOLD_CYC      = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    one_wire_slave_tx_if.slave   ow
);
    localparam int MAX_A = (PRES_WAIT_CYC > PRES_LEN_CYC) ? PRES_WAIT_CYC : PRES_LEN_CYC;
    localparam int MAX_C = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam int LW    = $clog2(RESET_MIN_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SLOT_HOLD, ST_SLOT_RECOVER, ST_PRES_WAIT, ST_PRES_DRIVE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   low_q, low_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      idx_q, idx_d;
    logic            armed_q, armed_d;
    logic            pull_q, pull_d;
    logic            done_q, done_d;
    logic            rseen_q, rseen_d;
    logic            pdone_q, pdone_d;
    logic            sync1_q, sync_q, sync_prev_q;
    logic            fall;
    logic            reset_hit;
    logic            ready;

    assign fall      = sync_prev_q & ~sync_q;
    assign ready     = (state_q == ST_IDLE) && !armed_q && ow.enable;
    // A saturated low counter stays saturated until the line rises, so it doubles as "reset pending".
    assign reset_hit = (low_q == LW'(RESET_MIN_CYC)) &&
                       (state_q != ST_PRES_WAIT) && (state_q != ST_PRES_DRIVE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        armed_d = armed_q;
        done_d  = 1'b0;
        rseen_d = 1'b0;
        pdone_d = 1'b0;
        low_d   = low_q;

        if (!ow.enable || sync_q || pull_q) begin
            low_d = '0;
        end else if (low_q != LW'(RESET_MIN_CYC)) begin
            low_d = low_q + LW'(1);
        end

        if (!ow.enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            armed_d = 1'b0;
            low_d   = '0;
        end else if (reset_hit) begin
            armed_d = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
            if (sync_q) begin
                state_d = ST_PRES_WAIT;
                rseen_d = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ow.load && ready) begin
                        shift_d = ow.tx_byte;
                        armed_d = 1'b1;
                        idx_d   = '0;
                    end else if (fall && armed_q) begin
                        state_d = ST_SLOT_HOLD;
                        cnt_d   = '0;
                    end
                end
                ST_SLOT_HOLD: begin
                    if (cnt_q == CW'(HOLD_CYC - 1)) begin
                        cnt_d   = '0;
                        shift_d = {1'b0, shift_q[7:1]};
                        state_d = ST_SLOT_RECOVER;
                        if (idx_q == 3'd7) begin
                            idx_d   = '0;
                            done_d  = 1'b1;
                            armed_d = 1'b0;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_SLOT_RECOVER: begin
                    if (sync_q) state_d = ST_IDLE;
                end
                ST_PRES_WAIT: begin
                    if (cnt_q == CW'(PRES_WAIT_CYC - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_PRES_DRIVE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_PRES_DRIVE: begin
                    if (cnt_q == CW'(PRES_LEN_CYC - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                        pdone_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        pull_d = ((state_d == ST_SLOT_HOLD) && !shift_d[0]) || (state_d == ST_PRES_DRIVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            low_q       <= '0;
            shift_q     <= '0;
            idx_q       <= '0;
            armed_q     <= 1'b0;
            pull_q      <= 1'b0;
            done_q      <= 1'b0;
            rseen_q     <= 1'b0;
            pdone_q     <= 1'b0;
            sync1_q     <= 1'b1;
            sync_q      <= 1'b1;
            sync_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            low_q       <= low_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            armed_q     <= armed_d;
            pull_q      <= pull_d;
            done_q      <= done_d;
            rseen_q     <= rseen_d;
            pdone_q     <= pdone_d;
            sync1_q     <= ow.bus_in;
            sync_q      <= sync1_q;
            sync_prev_q <= sync_q;
        end
    end

    assign ow.bus_pull_low  = pull_q;
    assign ow.ready         = ready;
    assign ow.busy          = armed_q || (state_q != ST_IDLE);
    assign ow.done          = done_q;
    assign ow.reset_seen    = rseen_q;
    assign ow.presence_done = pdone_q;
endmodule

// File: tb/tb_one_wire_slave_tx.sv
// Directed bench for one_wire_slave_tx: event-schedule model checked every cycle plus literal checks.
module tb_one_wire_slave_tx;
    localparam int RMIN = 480;
    localparam int PW   = 30;
    localparam int PL   = 120;
    localparam int HOLD = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    one_wire_slave_tx_if ow_if();

    one_wire_slave_tx #(
        .RESET_MIN_CYC(RMIN), .PRES_WAIT_CYC(PW), .PRES_LEN_CYC(PL), .HOLD_CYC(HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ow (ow_if)
    );

    int total = 0;
    int bad   = 0;

    // Model: cycle index since reset release, scheduled windows instead of states.
    int       m;
    int       hs, he, done_at, pres_at, nbits, low_run;
    bit       armed, rec, drv_bit;
    bit [7:0] byte_m;
    bit       b1, b2, b3;

    // Observations for the literal checks.
    int rs_count, rs_cyc, pull_first, pull_cnt, pd_cyc, done_cnt;
    bit seen_pull;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, m, act, exp);
        end
    endtask

    task automatic model_init();
        m = 0; hs = -1; he = -1; done_at = -1; pres_at = -1; nbits = 0; low_run = 0;
        armed = 0; rec = 0; drv_bit = 0; byte_m = '0;
        b1 = 1; b2 = 1; b3 = 1;
    endtask

    task automatic clr_stats();
        rs_count = 0; rs_cyc = -1; pull_first = -1; pull_cnt = 0; pd_cyc = -1; done_cnt = 0;
        seen_pull = 0;
    endtask

    task automatic model_check();
        bit s, sp, in_hold, in_pres, idle;
        bit e_pull, e_ready, e_busy, e_done, e_rs, e_pd;
        s  = b2;
        sp = b3;
        in_hold = (m >= hs) && (m <= he);
        in_pres = (pres_at >= 0) && (m >= pres_at) && (m <= pres_at + PW + PL - 1);
        idle    = !in_hold && !rec && !in_pres;
        e_pull  = (in_hold && drv_bit) || (in_pres && (m >= pres_at + PW));
        e_ready = idle && !armed && ow_if.enable;
        e_busy  = armed || !idle;
        e_done  = (m == done_at);
        e_rs    = (pres_at >= 0) && (m == pres_at);
        e_pd    = (pres_at >= 0) && (m == pres_at + PW + PL);

        chk("pull",  int'(ow_if.bus_pull_low),  int'(e_pull));
        chk("ready", int'(ow_if.ready),         int'(e_ready));
        chk("busy",  int'(ow_if.busy),          int'(e_busy));
        chk("done",  int'(ow_if.done),          int'(e_done));
        chk("rseen", int'(ow_if.reset_seen),    int'(e_rs));
        chk("pdone", int'(ow_if.presence_done), int'(e_pd));

        if (ow_if.reset_seen) begin rs_count++; rs_cyc = m; end
        if (ow_if.bus_pull_low) begin
            pull_cnt++;
            seen_pull = 1;
            if (pull_first < 0) pull_first = m;
        end
        if (ow_if.presence_done) pd_cyc = m;
        if (ow_if.done) done_cnt++;

        if (!ow_if.enable) begin
            armed = 0; nbits = 0; hs = -1; he = -1; done_at = -1; rec = 0; pres_at = -1;
        end else if (!in_pres && low_run == RMIN) begin
            armed = 0; nbits = 0; hs = -1; he = -1; rec = 0;
            if (s) pres_at = m + 1;
        end else if (idle) begin
            if (ow_if.load && e_ready) begin
                byte_m = ow_if.tx_byte; armed = 1; nbits = 0;
            end else if (sp && !s && armed) begin
                hs = m + 1; he = m + HOLD;
                drv_bit = !byte_m[nbits];
                if (nbits == 7) begin
                    done_at = he + 1; armed = 0; nbits = 0;
                end else begin
                    nbits++;
                end
            end
        end else begin
            if (rec && s) rec = 0;
            if (m == he) rec = 1;
        end

        if (!ow_if.enable || s || e_pull) low_run = 0;
        else if (low_run < RMIN) low_run++;

        b3 = b2; b2 = b1; b1 = ow_if.bus_in;
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
        m++;
    endtask

    task automatic hold(input bit v, input int n);
        ow_if.bus_in = v;
        repeat (n) step();
    endtask

    task automatic do_load(input bit [7:0] v);
        ow_if.load = 1; ow_if.tx_byte = v;
        step();
        ow_if.load = 0;
    endtask

    task automatic slot(output bit drove);
        seen_pull = 0;
        hold(0, 2);
        hold(1, 60);
        drove = seen_pull;
    endtask

    task automatic slots(input int n, output bit [7:0] mask);
        bit d;
        mask = '0;
        for (int i = 0; i < n; i++) begin
            slot(d);
            mask[i] = d;
        end
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 0;
        model_init();
    endtask

    initial begin
        bit [7:0] mask;
        bit       d0, d1;
        ow_if.enable = 1; ow_if.bus_in = 1; ow_if.load = 0; ow_if.tx_byte = '0;
        m = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pull",  int'(ow_if.bus_pull_low),  0);
        chk("rst_ready", int'(ow_if.ready),         1);
        chk("rst_busy",  int'(ow_if.busy),          0);
        chk("rst_done",  int'(ow_if.done),          0);
        chk("rst_rseen", int'(ow_if.reset_seen),    0);
        chk("rst_pdone", int'(ow_if.presence_done), 0);
        release_rst();
        clr_stats();
        hold(1, 5);

        // Master reset, then presence timing.
        clr_stats();
        hold(0, 500);
        hold(1, 250);
        chk("t1_rs_count", rs_count, 1);
        chk("t1_pres_gap", pull_first - rs_cyc, 30);
        chk("t1_pres_len", pull_cnt, 120);
        chk("t1_pdone_at", pd_cyc - rs_cyc, 150);

        // Too-short low is not a reset.
        clr_stats();
        hold(0, 400);
        hold(1, 20);
        chk("t2_rs_count", rs_count, 0);
        chk("t2_pull_cnt", pull_cnt, 0);

        // Full byte 0xA5.
        clr_stats();
        do_load(8'hA5);
        chk("t3_busy_armed", int'(ow_if.busy), 1);
        slots(8, mask);
        chk("t3_mask", int'(mask), 'h5A);
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_ready", int'(ow_if.ready), 1);

        // Reset mid-byte aborts it.
        clr_stats();
        do_load(8'h00);
        slots(3, mask);
        hold(0, 600);
        hold(1, 250);
        chk("t4_done_cnt", done_cnt, 0);
        chk("t4_rs_count", rs_count, 1);
        chk("t4_ready", int'(ow_if.ready), 1);
        chk("t4_busy",  int'(ow_if.busy),  0);

        // Reload while armed is ignored.
        clr_stats();
        do_load(8'h0F);
        slot(d0);
        do_load(8'hF0);
        slots(7, mask);
        mask = {mask[6:0], d0};
        chk("t5_mask", int'(mask), 'hF0);
        chk("t5_done_cnt", done_cnt, 1);

        // Load coinciding with a falling edge: slot skipped, byte starts next slot.
        clr_stats();
        ow_if.bus_in = 0; step(); step();
        ow_if.bus_in = 1;
        do_load(8'h00);
        seen_pull = 0;
        hold(1, 60);
        d0 = seen_pull;
        slot(d1);
        chk("t7_skip_slot", int'(d0), 0);
        chk("t7_next_slot", int'(d1), 1);

        // Enable low clears the armed byte.
        ow_if.enable = 0;
        hold(1, 1);
        chk("t8_ready_dis", int'(ow_if.ready), 0);
        hold(1, 4);
        chk("t8_busy_dis", int'(ow_if.busy), 0);
        ow_if.enable = 1;
        hold(1, 3);
        chk("t8_ready_en", int'(ow_if.ready), 1);

        // Async reset during the presence pulse.
        hold(0, 500);
        hold(1, 60);
        chk("t6_pull_pre", int'(ow_if.bus_pull_low), 1);
        #2;
        rst = 1;
        #1;
        chk("t6_pull_rst",  int'(ow_if.bus_pull_low), 0);
        chk("t6_ready_rst", int'(ow_if.ready), 1);
        chk("t6_busy_rst",  int'(ow_if.busy), 0);
        release_rst();
        hold(1, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
